// File: rtl/tp84_lpf_pkg.sv
// rtl/tp84_lpf_pkg.sv - widths, coefficient tables, FSM encoding and saturation for the LPF bank
package tp84_lpf_pkg;

  localparam int COEF_W = 18;
  localparam int SAMP_W = 16;
  localparam int ACC_W  = 36;
  localparam int PROD_W = SAMP_W + COEF_W;
  localparam int ERR_W  = 15;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_MB1  = 3'd1;
  localparam logic [2:0] ST_MB2  = 3'd2;
  localparam logic [2:0] ST_MA2  = 3'd3;
  localparam logic [2:0] ST_WR   = 3'd4;

  typedef enum logic [1:0] {
    MAC_HOLD = 2'd0,
    MAC_LOAD = 2'd1,
    MAC_ADD  = 2'd2,
    MAC_SUB  = 2'd3
  } mac_op_e;

  // Q15 coefficients indexed by sel: 0 bypass, 1 light, 2 medium, 3 heavy
  localparam logic [3:0][COEF_W-1:0] B1_TAB = {18'sd164, 18'sd640, 18'sd2048, 18'sd32768};
  localparam logic [3:0][COEF_W-1:0] B2_TAB = {18'sd164, 18'sd640, 18'sd2048, 18'sd0};
  localparam logic [3:0][COEF_W-1:0] A2_TAB = {-18'sd32440, -18'sd31488, -18'sd28672, 18'sd0};

  function automatic logic signed [SAMP_W-1:0] sat16(input logic signed [ACC_W-16:0] v);
    if (v > 21'sd32767)
      return 16'sh7fff;
    else if (v < -21'sd32768)
      return 16'sh8000;
    else
      return v[SAMP_W-1:0];
  endfunction

endpackage

// File: rtl/tp84_lpf_mac.sv
// rtl/tp84_lpf_mac.sv - shared 16x18 multiply-accumulate with floor shift and 16b saturation
//   optional TP84_LPF_ERRFB_EN adds a fractional bias on load and exposes the truncated bits
import tp84_lpf_pkg::*;

module tp84_lpf_mac (
  input  logic                     clk,
  input  logic                     rst_n,
  input  mac_op_e                  op,
  input  logic signed [SAMP_W-1:0] a,
  input  logic signed [COEF_W-1:0] b,
`ifdef TP84_LPF_ERRFB_EN
  input  logic [ERR_W-1:0]         bias,
  output logic [ERR_W-1:0]         frac,
`endif
  output logic signed [SAMP_W-1:0] y
);

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [ACC_W-1:0]  acc;

  assign prod     = a * b;
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
`ifdef TP84_LPF_ERRFB_EN
  assign bias_ext = {{(ACC_W-ERR_W){1'b0}}, bias};
  assign frac     = acc[ERR_W-1:0];
`else
  assign bias_ext = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else begin
      case (op)
        MAC_LOAD: acc <= prod_ext + bias_ext;
        MAC_ADD:  acc <= acc + prod_ext;
        MAC_SUB:  acc <= acc - prod_ext;
        default:  acc <= acc;
      endcase
    end
  end

  // acc[35:15] is acc>>>15, a floor toward minus infinity
  assign y = sat16(acc[ACC_W-1:15]);

endmodule

// File: rtl/tp84_lpf_multi.sv
// rtl/tp84_lpf_multi.sv - time-multiplexed first-order IIR low-pass bank, one MAC for NCH channels
//   define TP84_LPF_ERRFB_EN for per-channel truncation error feedback
import tp84_lpf_pkg::*;

module tp84_lpf_multi #(
  parameter int NCH = 3,
  parameter int DIV = 256
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [16*NCH-1:0]     in,
  input  logic [2*NCH-1:0]      sel,
  output logic [16*NCH-1:0]     out,
  output logic                  out_valid
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0]            cnt;
  logic                     tick;
  logic [2:0]               state;
  logic [2:0]               ch;
  logic [16*NCH-1:0]        in_cap;
  logic [2*NCH-1:0]         sel_cap;
  logic signed [SAMP_W-1:0] x1 [8];
  logic signed [SAMP_W-1:0] y1 [8];
  logic signed [SAMP_W-1:0] x_cur;
  logic [1:0]               sel_cur;
  logic signed [SAMP_W-1:0] y;
  mac_op_e                  op;
  logic signed [SAMP_W-1:0] mac_a;
  logic signed [COEF_W-1:0] mac_b;
`ifdef TP84_LPF_ERRFB_EN
  logic [ERR_W-1:0]         e [8];
  logic [ERR_W-1:0]         frac;
`endif

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt <= '0;
    else if (tick)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

  assign x_cur   = in_cap[16*ch +: 16];
  assign sel_cur = sel_cap[2*ch +: 2];

  always_comb begin
    op    = MAC_HOLD;
    mac_a = '0;
    mac_b = '0;
    case (state)
      ST_MB1: begin op = MAC_LOAD; mac_a = x_cur;  mac_b = $signed(B1_TAB[sel_cur]); end
      ST_MB2: begin op = MAC_ADD;  mac_a = x1[ch]; mac_b = $signed(B2_TAB[sel_cur]); end
      ST_MA2: begin op = MAC_SUB;  mac_a = y1[ch]; mac_b = $signed(A2_TAB[sel_cur]); end
      default: ;
    endcase
  end

  tp84_lpf_mac u_mac (
    .clk   (clk),
    .rst_n (reset_n),
    .op    (op),
    .a     (mac_a),
    .b     (mac_b),
`ifdef TP84_LPF_ERRFB_EN
    .bias  (e[ch]),
    .frac  (frac),
`endif
    .y     (y)
  );

  // A tick seen outside IDLE is dropped so the running sequence completes intact
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      ch        <= '0;
      in_cap    <= '0;
      sel_cap   <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        x1[i] <= '0;
        y1[i] <= '0;
`ifdef TP84_LPF_ERRFB_EN
        e[i]  <= '0;
`endif
      end
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tick) begin
            in_cap  <= in;
            sel_cap <= sel;
            ch      <= '0;
            state   <= ST_MB1;
          end
        end
        ST_MB1: state <= ST_MB2;
        ST_MB2: state <= ST_MA2;
        ST_MA2: state <= ST_WR;
        ST_WR: begin
          out[16*ch +: 16] <= y;
          x1[ch]           <= x_cur;
          y1[ch]           <= y;
`ifdef TP84_LPF_ERRFB_EN
          e[ch]            <= (sel_cur == 2'd0) ? '0 : frac;
`endif
          if (ch == 3'(NCH - 1)) begin
            state     <= ST_IDLE;
            out_valid <= 1'b1;
          end else begin
            ch    <= ch + 3'd1;
            state <= ST_MB1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
